serial_unswap48: RTL and testbench

Bit-serial to 48-bit parallel receiver with selectable bit order and a valid/ready handshake on both sides. It accepts one bit per cycle from a serial link and assembles it into a 48-bit word. With MSB-first ordering it restores a stream that was bit-reversed before transmission to native order. The datapath has a one-word holding register, so the next word can be collected while the consumer stalls.

---
 rtl/serial_unswap48.sv | 187 ++++++++++++++++++
 tb/tb_serial_unswap48.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_unswap48.sv
// Bit-serial to WIDTH-bit parallel receiver with a one-word holding register.
// Optional even-parity bit per word is enabled with `define SERIAL_UNSWAP_PARITY_EN.
module serial_unswap48 #(
  parameter  int WIDTH     = 48,
  parameter  int MSB_FIRST = 1,
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serialIn,
  input  logic             serialValid,
  output logic             serialReady,
  input  logic             frameAbort,
  output logic [WIDTH-1:0] wordOut,
  output logic             wordValid,
  input  logic             wordReady,
  output logic [CW-1:0]    bitCount
`ifdef SERIAL_UNSWAP_PARITY_EN
  ,
  output logic             parityErr
`endif
);

  // state  | meaning
  // FILL   | collecting data bits, bitCount = bits taken so far
  // PARITY | all data bits taken, waiting for the parity bit
  // PEND   | shift register holds a complete word, holding slot busy
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    PEND   = 2'd1
`ifdef SERIAL_UNSWAP_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d, shift_in;
  logic [WIDTH-1:0] word_q, word_d, load_word;
  logic             valid_q, valid_d;
  logic             accept, pop, slot_free, load;
`ifdef SERIAL_UNSWAP_PARITY_EN
  logic             par_q, par_d;
  logic             perr_pend_q, perr_pend_d;
  logic             perr_q, perr_d, load_perr;
`endif

  assign accept    = serialValid && (state_q != PEND);
  assign pop       = valid_q && wordReady;
  assign slot_free = !valid_q || wordReady;

  // Shifting toward the far end leaves the first bit at WIDTH-1 (MSB first) or at 0.
  assign shift_in = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], serialIn}
                                     : {serialIn, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word_d    = word_q;
    valid_d   = valid_q;
    load      = 1'b0;
    load_word = shift_q;
`ifdef SERIAL_UNSWAP_PARITY_EN
    par_d       = par_q;
    perr_pend_d = perr_pend_q;
    perr_d      = perr_q;
    load_perr   = perr_pend_q;
`endif

    if (frameAbort) begin
      state_d = FILL;
      cnt_d   = '0;
      shift_d = '0;
`ifdef SERIAL_UNSWAP_PARITY_EN
      par_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            shift_d = shift_in;
`ifdef SERIAL_UNSWAP_PARITY_EN
            par_d   = par_q ^ serialIn;
            if (cnt_q == LAST) begin
              state_d = PARITY;
              cnt_d   = FULL;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
`else
            if (cnt_q == LAST) begin
              if (slot_free) begin
                load      = 1'b1;
                load_word = shift_in;
                cnt_d     = '0;
              end else begin
                state_d = PEND;
                cnt_d   = FULL;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
`endif
          end
        end
`ifdef SERIAL_UNSWAP_PARITY_EN
        PARITY: begin
          if (accept) begin
            par_d       = 1'b0;
            perr_pend_d = par_q ^ serialIn;
            if (slot_free) begin
              load      = 1'b1;
              load_word = shift_q;
              load_perr = par_q ^ serialIn;
              cnt_d     = '0;
              state_d   = FILL;
            end else begin
              state_d = PEND;
            end
          end
        end
`endif
        PEND: begin
          if (slot_free) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = FILL;
          end
        end
        default: begin
          state_d = FILL;
          cnt_d   = '0;
        end
      endcase
    end

    if (load) begin
      word_d  = load_word;
      valid_d = 1'b1;
`ifdef SERIAL_UNSWAP_PARITY_EN
      perr_d  = load_perr;
`endif
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
`ifdef SERIAL_UNSWAP_PARITY_EN
      par_q       <= 1'b0;
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
`ifdef SERIAL_UNSWAP_PARITY_EN
      par_q       <= par_d;
      perr_pend_q <= perr_pend_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign serialReady = (state_q != PEND);
  assign wordOut     = word_q;
  assign wordValid   = valid_q;
  assign bitCount    = cnt_q;
`ifdef SERIAL_UNSWAP_PARITY_EN
  assign parityErr   = perr_q;
`endif

endmodule

// File: tb/tb_serial_unswap48.sv
// Scoreboard bench for serial_unswap48: MSB-first and LSB-first instances share one stimulus
// stream; a transaction-level model predicts words, readiness and bit counts.
module tb_serial_unswap48;
  localparam int W  = 48;
  localparam int CW = $clog2(W + 1);
`ifdef SERIAL_UNSWAP_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic clk = 1'b0;
  logic rst, serialIn, serialValid, frameAbort, wordReady;
  logic ready_m, ready_l, valid_m, valid_l;
  logic [W-1:0] out_m, out_l;
  logic [CW-1:0] cnt_m, cnt_l;
`ifdef SERIAL_UNSWAP_PARITY_EN
  logic perr_m, perr_l;
`endif

  always #5 clk = ~clk;

  serial_unswap48 #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .serialIn(serialIn), .serialValid(serialValid),
    .serialReady(ready_m), .frameAbort(frameAbort), .wordOut(out_m),
    .wordValid(valid_m), .wordReady(wordReady), .bitCount(cnt_m)
`ifdef SERIAL_UNSWAP_PARITY_EN
    , .parityErr(perr_m)
`endif
  );

  serial_unswap48 #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .serialIn(serialIn), .serialValid(serialValid),
    .serialReady(ready_l), .frameAbort(frameAbort), .wordOut(out_l),
    .wordValid(valid_l), .wordReady(wordReady), .bitCount(cnt_l)
`ifdef SERIAL_UNSWAP_PARITY_EN
    , .parityErr(perr_l)
`endif
  );

  int checks = 0;
  int passes = 0;

  // Model: bits of the word in progress, a completed word waiting for the slot, slot occupancy.
  bit           m_bits[$];
  bit           m_pend, m_valid;
  logic [W-1:0] pend_m, pend_l;
  bit           pend_p;
  logic [W-1:0] exp_m[$], exp_l[$];
  bit           exp_p[$];
  logic [W-1:0] last_m, last_l;
  bit           last_p;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [CW-1:0] model_cnt();
    return m_pend ? CW'(W) : CW'(m_bits.size());
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_pend  = 0;
    m_valid = 0;
    exp_m.delete();
    exp_l.delete();
    exp_p.delete();
  endtask

  task automatic model_edge();
    bit pop, slot_free, load, wp;
    logic [W-1:0] wm, wl;
    pop       = m_valid && wordReady;
    slot_free = !m_valid || wordReady;
    load      = 0;
    wm = '0; wl = '0; wp = 0;
    if (frameAbort) begin
      m_bits.delete();
      m_pend = 0;
    end else if (m_pend) begin
      if (slot_free) begin
        load = 1; wm = pend_m; wl = pend_l; wp = pend_p;
        m_pend = 0;
      end
    end else if (serialValid) begin
      m_bits.push_back(serialIn);
      if (m_bits.size() == NB) begin
        for (int k = 0; k < W; k++) begin
          wm[W-1-k] = m_bits[k];
          wl[k]     = m_bits[k];
        end
        for (int k = 0; k < NB; k++) wp ^= m_bits[k];
        m_bits.delete();
        if (slot_free) load = 1;
        else begin
          m_pend = 1; pend_m = wm; pend_l = wl; pend_p = wp;
        end
      end
    end
    if (load) begin
      exp_m.push_back(wm);
      exp_l.push_back(wl);
      exp_p.push_back(wp);
      m_valid = 1;
    end else if (pop) begin
      m_valid = 0;
    end
  endtask

  // Inputs are applied just after an edge and held through the next one.
  task automatic step(input bit v, input bit b, input bit r, input bit a);
    serialValid = v;
    serialIn    = b;
    wordReady   = r;
    frameAbort  = a;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit r);
    for (int i = W - 1; i >= 0; i--) step(1'b1, w[i], r, 1'b0);
`ifdef SERIAL_UNSWAP_PARITY_EN
    step(1'b1, ^w, r, 1'b0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wordOut_msb"}, out_m, 0);
    check({tag, "_wordOut_lsb"}, out_l, 0);
    check({tag, "_wordValid"}, {valid_m, valid_l}, 0);
    check({tag, "_serialReady"}, {ready_m, ready_l}, 2'b11);
    check({tag, "_bitCount"}, {cnt_m, cnt_l}, 0);
`ifdef SERIAL_UNSWAP_PARITY_EN
    check({tag, "_parityErr"}, {perr_m, perr_l}, 0);
`endif
  endtask

  // Monitor: per-cycle state against the model, and word pops against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check("serialReady_msb", ready_m, !m_pend);
      check("serialReady_lsb", ready_l, !m_pend);
      check("wordValid_msb", valid_m, m_valid);
      check("wordValid_lsb", valid_l, m_valid);
      check("bitCount_msb", cnt_m, model_cnt());
      check("bitCount_lsb", cnt_l, model_cnt());
      if (m_valid && wordReady) begin
        if (exp_m.size() == 0) begin
          checks++;
          $display("FAIL scoreboard_underflow: word popped with no expected entry (t=%0t)", $time);
        end else begin
          check("wordOut_msb", out_m, exp_m.pop_front());
          check("wordOut_lsb", out_l, exp_l.pop_front());
          last_p = exp_p.pop_front();
`ifdef SERIAL_UNSWAP_PARITY_EN
          check("parityErr_msb", perr_m, last_p);
          check("parityErr_lsb", perr_l, last_p);
          last_p = perr_m;
`endif
          last_m = out_m;
          last_l = out_l;
        end
      end
    end
  end

  initial begin
    rst = 1; serialIn = 0; serialValid = 0; frameAbort = 0; wordReady = 0;
    last_m = '0; last_l = '0; last_p = 0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 0;

    // Reference word, consumer always ready: one-cycle wordValid right after the last bit.
    send_word(48'hA5A5_0F0F_1234, 1'b1);
    check("latency_valid", valid_m, 1);
    idle(1);
    check("valid_one_cycle", valid_m, 0);
    check("directed_msb", last_m, 48'hA5A5_0F0F_1234);
    check("directed_lsb", last_l, 48'h2C48_F0F0_A5A5);

    // Two words against a stalled consumer, then a single pop cycle.
    send_word(48'h1111_2222_3333, 1'b0);
    send_word(48'h4444_5555_6666, 1'b0);
    check("pend_ready_low", ready_m, 0);
    check("held_first_word", out_m, 48'h1111_2222_3333);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("pend_load_valid", valid_m, 1);
    check("pend_load_word", out_m, 48'h4444_5555_6666);
    check("pend_ready_back", ready_m, 1);
    idle(2);

    // Abort after 20 bits with a word held, abort concurrent with a valid bit.
    send_word(48'h0123_4567_89AB, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("abort_count", cnt_m, 0);
    check("abort_valid_kept", valid_m, 1);
    check("abort_hold_kept", out_m, 48'h0123_4567_89AB);
    idle(1);
    send_word(48'hFFFF_0000_FFFF, 1'b1);
    idle(1);
    check("after_abort_word", last_m, 48'hFFFF_0000_FFFF);

    // Asynchronous reset with a held word and 30 bits in flight.
    send_word(48'hDEAD_BEEF_CAFE, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    serialValid = 0; wordReady = 0;
    #2 rst = 1;
    #1 check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    send_word(48'h8000_0000_0001, 1'b1);
    idle(1);
    check("post_reset_word", last_m, 48'h8000_0000_0001);

`ifdef SERIAL_UNSWAP_PARITY_EN
    for (int i = W - 1; i >= 0; i--) step(1'b1, (i == 0), 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("parity_good_valid", valid_m, 1);
    idle(1);
    check("parity_good", last_p, 0);
    for (int i = W - 1; i >= 0; i--) step(1'b1, (i == 0), 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("parity_bad", last_p, 1);
`endif

    // Randomized traffic with stalls and occasional aborts.
    for (int i = 0; i < 4000; i++) begin
      bit v, r, a;
      v = ($urandom_range(0, 3) != 0);
      r = ((i / 300) % 2 == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 249) == 0);
      step(v, 1'($urandom_range(0, 1)), r, a);
    end

    idle(200);
    check("scoreboard_drained", exp_m.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
